// File: rtl/ahbl_rgb_pwm.sv
`timescale 1ns/1ps
// AHB-Lite slave generating three double-buffered 8-bit PWM channels for the RGB LED driver.
// Zero-wait-state bus; duty updates take effect at period wrap so no period is ever glitched.

module ahbl_rgb_pwm (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic [2:0]  pwm_out
);

    typedef enum logic [2:0] {
        REG_CTRL   = 3'd0,
        REG_PRESC  = 3'd1,
        REG_DUTY0  = 3'd2,
        REG_DUTY1  = 3'd3,
        REG_DUTY2  = 3'd4,
        REG_STATUS = 3'd5
    } reg_sel_e;

    // Bus data-phase tracking
    logic        dp_valid_q;
    logic        dp_write_q;
    logic [2:0]  dp_addr_q;
    logic        wr_en;
    logic        rd_en;

    // Software-visible registers
    logic        en_q,    en_d;
    logic        inv_q,   inv_d;
    logic [15:0] presc_q, presc_d;
    logic [2:0][7:0] duty_q, duty_d;
    logic        pdone_q, pdone_d;

    // PWM core state
    logic [15:0] pcnt_q, pcnt_d;
    logic [7:0]  cnt_q,  cnt_d;
    logic [2:0][7:0] act_q, act_d;
    logic [2:0]  pwm_q,  pwm_d;
    logic        tick;
    logic        wrap;

    logic        unused_bits;
    assign unused_bits = ^{HSIZE, HADDR[31:5], HADDR[1:0], HWDATA[31:16]};

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign pwm_out   = pwm_q;

    // The address phase is captured only when the whole bus advances.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!HRESETn) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= 3'd0;
        end else if (HREADY) begin
            dp_valid_q <= HSEL & HTRANS[1];
            dp_write_q <= HWRITE;
            dp_addr_q  <= HADDR[4:2];
        end
    end

    assign wr_en = dp_valid_q & dp_write_q & HREADY;
    assign rd_en = dp_valid_q & ~dp_write_q;

    assign tick = en_q && (pcnt_q >= presc_q);
    assign wrap = tick && (cnt_q == 8'hFF);

    always_comb begin
        // NOTE: every output of this block is defaulted first so no latch is inferred.
        en_d    = en_q;
        inv_d   = inv_q;
        presc_d = presc_q;
        duty_d  = duty_q;
        pdone_d = pdone_q;
        if (wr_en) begin
            case (dp_addr_q)
                REG_CTRL: begin
                    en_d  = HWDATA[0];
                    inv_d = HWDATA[1];
                end
                REG_PRESC:  presc_d   = HWDATA[15:0];
                REG_DUTY0:  duty_d[0] = HWDATA[7:0];
                REG_DUTY1:  duty_d[1] = HWDATA[7:0];
                REG_DUTY2:  duty_d[2] = HWDATA[7:0];
                REG_STATUS: if (HWDATA[0]) pdone_d = 1'b0;
                default: ;
            endcase
        end
        // A wrap in the same cycle as a clear must not be lost.
        if (wrap) pdone_d = 1'b1;
    end

    always_comb begin
        pcnt_d = pcnt_q;
        cnt_d  = cnt_q;
        act_d  = act_q;
        if (!en_q) begin
            pcnt_d = 16'd0;
            cnt_d  = 8'd0;
            act_d  = duty_q;
        end else begin
            if (tick) begin
                pcnt_d = 16'd0;
                cnt_d  = cnt_q + 8'd1;
            end else begin
                pcnt_d = pcnt_q + 16'd1;
            end
            if (wrap) act_d = duty_q;
        end
    end

    always_comb begin
        pwm_d = 3'b000;
        for (int i = 0; i < 3; i++) begin
            pwm_d[i] = en_q & ((cnt_q < act_q[i]) ^ inv_q);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            en_q    <= 1'b0;
            inv_q   <= 1'b0;
            presc_q <= 16'd0;
            duty_q  <= '0;
            pdone_q <= 1'b0;
            pcnt_q  <= 16'd0;
            cnt_q   <= 8'd0;
            act_q   <= '0;
            pwm_q   <= 3'b000;
        end else begin
            en_q    <= en_d;
            inv_q   <= inv_d;
            presc_q <= presc_d;
            duty_q  <= duty_d;
            pdone_q <= pdone_d;
            pcnt_q  <= pcnt_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            pwm_q   <= pwm_d;
        end
    end

    always_comb begin
        HRDATA = 32'd0;
        if (rd_en) begin
            case (dp_addr_q)
                REG_CTRL:   HRDATA = {30'd0, inv_q, en_q};
                REG_PRESC:  HRDATA = {16'd0, presc_q};
                REG_DUTY0:  HRDATA = {24'd0, duty_q[0]};
                REG_DUTY1:  HRDATA = {24'd0, duty_q[1]};
                REG_DUTY2:  HRDATA = {24'd0, duty_q[2]};
                REG_STATUS: HRDATA = {31'd0, pdone_q};
                default:    HRDATA = 32'd0;
            endcase
        end
    end

endmodule
